dm_tag_cache_responder: RTL and testbench



---
 rtl/cache_sim_pkg.sv | 36 +++
 rtl/dm_tag_store.sv | 39 +++
 rtl/dm_tag_cache_responder.sv | 121 ++++++++++++
 tb/tb_dm_tag_cache_responder.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/cache_sim_pkg.sv
// Shared widths, FSM state type and address-field helpers for the tag cache model.
package cache_sim_pkg;

  localparam int unsigned ADDR_W_DEF   = 32;
  localparam int unsigned OFFSET_W_DEF = 6;
  localparam int unsigned INDEX_W_DEF  = 10;
  localparam int unsigned CNT_W_DEF    = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RESP = 2'd2
  } state_e;

  // Tag width left over once index and offset are carved out of the address.
  function automatic int unsigned tag_w(input int unsigned addr_w,
                                        input int unsigned index_w,
                                        input int unsigned offset_w);
    return addr_w - index_w - offset_w;
  endfunction

  // Tag field, right-aligned; callers cast to their tag width.
  function automatic logic [63:0] get_tag(input logic [63:0] addr,
                                          input int unsigned index_w,
                                          input int unsigned offset_w);
    return addr >> (index_w + offset_w);
  endfunction

  // Index field, right-aligned; callers cast to their index width.
  function automatic logic [63:0] get_index(input logic [63:0] addr,
                                            input int unsigned index_w,
                                            input int unsigned offset_w);
    return (addr >> offset_w) & ((64'd1 << index_w) - 64'd1);
  endfunction

endpackage

// File: rtl/dm_tag_store.sv
// Tag RAM with synchronous read plus a per-line valid flop array.
module dm_tag_store #(
  parameter int unsigned INDEX_W = 10,
  parameter int unsigned TAG_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rd_en,
  input  logic [INDEX_W-1:0] rd_idx,
  output logic [TAG_W-1:0]   rd_tag,
  output logic               rd_valid,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0]   wr_tag
);

  localparam int unsigned LINES = 1 << INDEX_W;

  logic [TAG_W-1:0] tag_mem [LINES];
  logic [LINES-1:0] valid_q;

  // Tag array: contents are never reset, the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (wr_en) tag_mem[wr_idx] <= wr_tag;
    if (rd_en) rd_tag <= tag_mem[rd_idx];
  end

  // Valid bits: cleared on reset, set when a line is installed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (wr_en) valid_q[wr_idx] <= 1'b1;
      if (rd_en) rd_valid <= valid_q[rd_idx];
    end
  end

endmodule

// File: rtl/dm_tag_cache_responder.sv
// Direct-mapped tag-only cache responding to a trace strobe with hit/miss pulses.
module dm_tag_cache_responder
  import cache_sim_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned OFFSET_W = OFFSET_W_DEF,
  parameter int unsigned INDEX_W  = INDEX_W_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              trace_ready,
  input  logic [ADDR_W-1:0] mem_addr,
  output logic              found_in_cache,
  output logic              updated,
  output logic [CNT_W-1:0]  cache_hit_count,
  output logic [CNT_W-1:0]  cache_miss_count,
  output logic              busy,
  output logic              proto_err
);

  localparam int unsigned TAG_W = tag_w(ADDR_W, INDEX_W, OFFSET_W);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e             state_q, state_d;
  logic               trace_ready_q;
  logic               start_c, rd_en_c, hit_c, miss_c;
  logic [TAG_W-1:0]   addr_tag_c, tag_q, rd_tag;
  logic [INDEX_W-1:0] addr_idx_c, idx_q;
  logic               rd_valid;

  assign start_c    = trace_ready & ~trace_ready_q;
  assign addr_tag_c = TAG_W'(get_tag(64'(mem_addr), INDEX_W, OFFSET_W));
  assign addr_idx_c = INDEX_W'(get_index(64'(mem_addr), INDEX_W, OFFSET_W));

  dm_tag_store #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W)
  ) u_store (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_en    (rd_en_c),
    .rd_idx   (addr_idx_c),
    .rd_tag   (rd_tag),
    .rd_valid (rd_valid),
    .wr_en    (miss_c),
    .wr_idx   (idx_q),
    .wr_tag   (tag_q)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state, lookup issue and hit/miss decision.
  always_comb begin
    state_d = state_q;
    rd_en_c = 1'b0;
    hit_c   = 1'b0;
    miss_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_c) begin
          rd_en_c = 1'b1;
          state_d = CMP;
        end
      end
      CMP: begin
        if (rd_valid && (rd_tag == tag_q)) hit_c  = 1'b1;
        else                               miss_c = 1'b1;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture the address fields of an accepted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q <= '0;
      idx_q <= '0;
    end else if (rd_en_c) begin
      tag_q <= addr_tag_c;
      idx_q <= addr_idx_c;
    end
  end

  // Edge detect, response pulses, busy and sticky protocol error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trace_ready_q  <= 1'b0;
      found_in_cache <= 1'b0;
      updated        <= 1'b0;
      busy           <= 1'b0;
      proto_err      <= 1'b0;
    end else begin
      trace_ready_q  <= trace_ready;
      found_in_cache <= hit_c;
      updated        <= miss_c;
      busy           <= (state_d != IDLE);
      if (start_c && (state_q != IDLE)) proto_err <= 1'b1;
    end
  end

  // Saturating hit and miss counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cache_hit_count  <= '0;
      cache_miss_count <= '0;
    end else begin
      if (hit_c && (cache_hit_count != CNT_MAX))
        cache_hit_count <= cache_hit_count + CNT_W'(1);
      if (miss_c && (cache_miss_count != CNT_MAX))
        cache_miss_count <= cache_miss_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_dm_tag_cache_responder.sv
// Bench for dm_tag_cache_responder: directed table, corner sequences, random vs. model.
module tb_dm_tag_cache_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        trace_ready;
  logic [31:0] mem_addr;
  logic        found_in_cache, updated, busy, proto_err;
  logic [31:0] cache_hit_count, cache_miss_count;

  int errors = 0;
  int checks = 0;

  dm_tag_cache_responder dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .trace_ready      (trace_ready),
    .mem_addr         (mem_addr),
    .found_in_cache   (found_in_cache),
    .updated          (updated),
    .cache_hit_count  (cache_hit_count),
    .cache_miss_count (cache_miss_count),
    .busy             (busy),
    .proto_err        (proto_err)
  );

  always #5 clk = ~clk;

  // Reference model: 1024 lines of {valid, 16-bit tag}, saturating 32-bit counts.
  bit          m_valid [1024];
  logic [15:0] m_tag   [1024];
  longint      m_hit, m_miss;
  localparam longint CMAX = 64'h0000_0000_FFFF_FFFF;

  function automatic void model_reset();
    for (int i = 0; i < 1024; i++) m_valid[i] = 1'b0;
    m_hit  = 0;
    m_miss = 0;
  endfunction

  function automatic bit model_access(input logic [31:0] a);
    int          idx;
    logic [15:0] tg;
    bit          h;
    idx = int'(a / 64) % 1024;
    tg  = 16'(a / 65536);
    h   = m_valid[idx] && (m_tag[idx] == tg);
    if (h) begin
      if (m_hit < CMAX) m_hit = m_hit + 1;
    end else begin
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
      if (m_miss < CMAX) m_miss = m_miss + 1;
    end
    return h;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // One full transaction with fixed two-cycle latency checks.
  task automatic apply_txn(input logic [31:0] a, input bit exp_found,
                           input longint exp_h, input longint exp_m, input string name);
    @(negedge clk);
    mem_addr    = a;
    trace_ready = 1'b1;
    @(posedge clk); #1;
    check({name, " busy@N"}, 64'(busy), 64'd1);
    check({name, " nopulse@N"}, 64'({found_in_cache, updated}), 64'd0);
    @(posedge clk); #1;
    check({name, " found"}, 64'(found_in_cache), 64'(exp_found));
    check({name, " updated"}, 64'(updated), 64'(!exp_found));
    check({name, " hits"}, 64'(cache_hit_count), 64'(exp_h));
    check({name, " misses"}, 64'(cache_miss_count), 64'(exp_m));
    @(negedge clk);
    trace_ready = 1'b0;
    @(posedge clk); #1;
    check({name, " clear@N+2"}, 64'({found_in_cache, updated, busy}), 64'd0);
  endtask

  typedef struct {
    logic [31:0] addr;
    bit          found;
    longint      hits;
    longint      misses;
  } vec_t;

  vec_t vecs [9];
  int   nf, nu;

  initial begin
    vecs[0] = '{32'h0000_0040, 1'b0, 0, 1};
    vecs[1] = '{32'h0000_0040, 1'b1, 1, 1};
    vecs[2] = '{32'h0000_007F, 1'b1, 2, 1};
    vecs[3] = '{32'h0001_0040, 1'b0, 2, 2};
    vecs[4] = '{32'h0000_0040, 1'b0, 2, 3};
    vecs[5] = '{32'h0001_0040, 1'b0, 2, 4};
    vecs[6] = '{32'h0000_003F, 1'b0, 2, 5};
    vecs[7] = '{32'hFFFF_FFC0, 1'b0, 2, 6};
    vecs[8] = '{32'hFFFF_FFFF, 1'b1, 3, 6};

    rst_n       = 1'b0;
    trace_ready = 1'b0;
    mem_addr    = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset pulses", 64'({found_in_cache, updated}), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset proto_err", 64'(proto_err), 64'd0);
    check("reset hits", 64'(cache_hit_count), 64'd0);
    check("reset misses", 64'(cache_miss_count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 9; i++) begin
      void'(model_access(vecs[i].addr));
      apply_txn(vecs[i].addr, vecs[i].found, vecs[i].hits, vecs[i].misses,
                $sformatf("vec%0d", i));
    end

    // Level held for 4 cycles: exactly one response
    void'(model_access(32'h0000_1000));
    nf = 0; nu = 0;
    @(negedge clk);
    mem_addr    = 32'h0000_1000;
    trace_ready = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      nf += int'(found_in_cache);
      nu += int'(updated);
    end
    @(negedge clk);
    trace_ready = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      nf += int'(found_in_cache);
      nu += int'(updated);
    end
    check("hold updated count", 64'(nu), 64'd1);
    check("hold found count", 64'(nf), 64'd0);
    check("hold misses", 64'(cache_miss_count), 64'(m_miss));
    check("hold proto_err", 64'(proto_err), 64'd0);

    // Second rising edge while busy: ignored, proto_err set
    void'(model_access(32'h0000_2000));
    @(negedge clk);
    mem_addr    = 32'h0000_2000;
    trace_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    trace_ready = 1'b0;
    @(posedge clk); #1;
    check("proto first updated", 64'(updated), 64'd1);
    @(negedge clk);
    mem_addr    = 32'h0000_3000;
    trace_ready = 1'b1;
    @(posedge clk); #1;
    check("proto_err set", 64'(proto_err), 64'd1);
    check("proto ignored busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    check("proto no retrigger", 64'(busy), 64'd0);
    @(negedge clk);
    trace_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("proto pulses", 64'({found_in_cache, updated}), 64'd0);
    check("proto hits", 64'(cache_hit_count), 64'(m_hit));
    check("proto misses", 64'(cache_miss_count), 64'(m_miss));
    check("proto_err sticky", 64'(proto_err), 64'd1);

    // Reset during CMP of a cached line
    void'(model_access(32'h0000_0040));
    apply_txn(32'h0000_0040, 1'b0, m_hit, m_miss, "precache");
    @(negedge clk);
    mem_addr    = 32'h0000_0040;
    trace_ready = 1'b1;
    @(posedge clk); #1;
    check("rst busy@CMP", 64'(busy), 64'd1);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst mid hits", 64'(cache_hit_count), 64'd0);
    check("rst mid misses", 64'(cache_miss_count), 64'd0);
    check("rst mid busy/err", 64'({busy, proto_err}), 64'd0);
    @(negedge clk);
    trace_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      check("rst no pulse", 64'({found_in_cache, updated}), 64'd0);
    end
    void'(model_access(32'h0000_0040));
    apply_txn(32'h0000_0040, 1'b0, 0, 1, "after rst");

    // Hit counter saturation
    @(negedge clk);
    force dut.cache_hit_count = 32'hFFFF_FFFE;
    #1;
    release dut.cache_hit_count;
    m_hit = 64'h0000_0000_FFFF_FFFE;
    void'(model_access(32'h0000_0040));
    apply_txn(32'h0000_0040, 1'b1, m_hit, m_miss, "sat1");
    void'(model_access(32'h0000_0040));
    apply_txn(32'h0000_0040, 1'b1, m_hit, m_miss, "sat2");
    check("sat value", 64'(cache_hit_count), 64'h0000_0000_FFFF_FFFF);

    // Random traffic over a small tag/index pool against the model
    for (int i = 0; i < 150; i++) begin
      logic [31:0] a;
      bit          f;
      if (i % 8 == 7) a = $urandom;
      else a = ($urandom_range(0, 3) << 16) | ($urandom_range(0, 7) << 6) | $urandom_range(0, 63);
      f = model_access(a);
      apply_txn(a, f, m_hit, m_miss, $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
